// File: rtl/rtc_bus_arbiter.sv
// Two-requester round-robin arbiter owning the multiplexed RTC address/data bus.
// Each grant runs one single-byte transaction with the address and data phase strobe timing.
module rtc_bus_arbiter #(
  parameter int unsigned T_ADDR  = 5,
  parameter int unsigned T_GAP   = 8,
  parameter int unsigned T_DATA  = 5,
  parameter int unsigned T_RECOV = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       we0,
  input  logic [7:0] addr0,
  input  logic [7:0] wdata0,
  input  logic       req1,
  input  logic       we1,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       busy,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad,
  output logic       wr,
  output logic       rd,
  output logic       cs
);

  typedef enum logic [3:0] {
    IDLE, ADDR_CS, ADDR_WR, ADDR_DRV, ADDR_HOLD, ADDR_CSOFF, ADDR_REL,
    GAP, DATA_START, DATA_HOLD, DATA_CSOFF, ACK, RECOV
  } state_t;

  localparam logic [3:0] A_LD = 4'(T_ADDR - 1);
  localparam logic [3:0] G_LD = 4'(T_GAP - 1);
  localparam logic [3:0] D_LD = 4'(T_DATA - 1);
  localparam logic [3:0] R_LD = 4'(T_RECOV - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       last_grant;
  logic       g_sel;
  logic       g_we;
  logic [7:0] g_addr;
  logic [7:0] g_wdata;

  logic arb_point;
  logic arb_req;
  logic arb_sel;

  // The last recovery edge doubles as the arbitration edge, so a waiting
  // request is granted on the same edge the arbiter would have gone idle.
  always_comb begin
    arb_req   = req0 | req1;
    arb_sel   = ~(req0 & (~req1 | last_grant));
    arb_point = (state == IDLE)
             || (state == RECOV && cnt == '0)
             || (state == ACK && T_RECOV == 0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      g_sel      <= 1'b0;
      g_we       <= 1'b0;
      g_addr     <= '0;
      g_wdata    <= '0;
      ad_out     <= '1;
      ad         <= 1'b1;
      wr         <= 1'b1;
      rd         <= 1'b1;
      cs         <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
    end else if (arb_point && arb_req) begin
      state      <= ADDR_CS;
      ad         <= 1'b0;
      busy       <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      g_sel      <= arb_sel;
      last_grant <= arb_sel;
      g_we       <= arb_sel ? we1    : we0;
      g_addr     <= arb_sel ? addr1  : addr0;
      g_wdata    <= arb_sel ? wdata1 : wdata0;
    end else begin
      case (state)
        IDLE: busy <= 1'b0;
        ADDR_CS: begin
          cs    <= 1'b0;
          state <= ADDR_WR;
        end
        ADDR_WR: begin
          wr    <= 1'b0;
          state <= ADDR_DRV;
        end
        ADDR_DRV: begin
          ad_out <= g_addr;
          cnt    <= A_LD;
          state  <= ADDR_HOLD;
        end
        ADDR_HOLD: begin
          if (cnt == '0) begin
            wr    <= 1'b1;
            state <= ADDR_CSOFF;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ADDR_CSOFF: begin
          cs    <= 1'b1;
          state <= ADDR_REL;
        end
        ADDR_REL: begin
          ad     <= 1'b1;
          ad_out <= '1;
          cnt    <= G_LD;
          state  <= GAP;
        end
        GAP: begin
          if (cnt == '0) begin
            cs    <= 1'b0;
            state <= DATA_START;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DATA_START: begin
          if (g_we) begin
            wr     <= 1'b0;
            ad_out <= g_wdata;
          end else begin
            rd <= 1'b0;
          end
          cnt   <= D_LD;
          state <= DATA_HOLD;
        end
        DATA_HOLD: begin
          if (cnt == '0) begin
            rd <= 1'b1;
            wr <= 1'b1;
            if (!g_we) rdata <= ad_in;
            state <= DATA_CSOFF;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DATA_CSOFF: begin
          cs     <= 1'b1;
          ad_out <= '1;
          ack0   <= ~g_sel;
          ack1   <= g_sel;
          state  <= ACK;
        end
        ACK: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (T_RECOV == 0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt   <= R_LD;
            state <= RECOV;
          end
        end
        RECOV: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
